// File: rtl/pipe_pkg.sv
// Shared PIPE encodings (power states, rates, receiver-detect status) and controller FSM states.
package pipe_pkg;

   typedef enum logic [3:0] {
      PD_P0  = 4'd0,
      PD_P0S = 4'd1,
      PD_P1  = 4'd2,
      PD_P2  = 4'd3
   } powerDown_e;

   typedef enum logic [3:0] {
      RATE_GEN1 = 4'd0,
      RATE_GEN2 = 4'd1,
      RATE_GEN3 = 4'd2,
      RATE_GEN4 = 4'd3,
      RATE_GEN5 = 4'd4
   } rate_e;

   typedef enum logic [2:0] {
      RXSTAT_NONE     = 3'b000,
      RXSTAT_DETECTED = 3'b011
   } rxStatus_e;

   typedef enum logic [2:0] {
      RST_HOLD,
      IDLE,
      PD_BUSY,
      DET_BUSY,
      RATE_OK,
      RATE_SETTLE,
      RATE_DONE,
      WAIT_ACK_LOW
   } phyState_e;

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pipe_phy_ctrl.sv
// PIPE PHY-side control: reset hold, power-state change, rate handshake, receiver detect.
// Each operation: fixed busy latency then a one-cycle PhyStatus; MAC requests are level-held until served.
module pipe_phy_ctrl
   import pipe_pkg::*;
#(
   parameter int LANESNUMBER    = 16,
   parameter int RESET_CYCLES   = 8,
   parameter int DETECT_LATENCY = 8,
   parameter int PD_LATENCY     = 4,
   parameter int RATE_LATENCY   = 16,
   parameter int MAX_RATE       = 4
)(
   input  logic                     CLK,
   input  logic                     reset,
   input  logic [3:0]               PowerDown,
   input  logic [3:0]               Rate,
   input  logic [LANESNUMBER-1:0]   TxDetectRx_Loopback,
   input  logic [LANESNUMBER-1:0]   TxElecIdle,
   input  logic [LANESNUMBER-1:0]   RxPresent,
   input  logic                     PclkChangeAck,
   output logic                     PclkChangeOk,
   output logic                     PhyStatus,
   output logic [3*LANESNUMBER-1:0] RxStatus,
   output logic [3:0]               CurrentPowerDown,
   output logic [3:0]               CurrentRate
);

   localparam int MAX_LAT = maxOf(maxOf(RESET_CYCLES, DETECT_LATENCY), maxOf(PD_LATENCY, RATE_LATENCY));
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [3:0]       MAX_RATE_CODE = 4'(MAX_RATE);
   localparam logic [CNT_W-1:0] RESET_LOAD    = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] DET_LOAD      = CNT_W'(DETECT_LATENCY - 1);
   localparam logic [CNT_W-1:0] PD_LOAD       = CNT_W'(PD_LATENCY - 1);
   localparam logic [CNT_W-1:0] RATE_LOAD     = CNT_W'(RATE_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

   phyState_e                state, stateNext;
   logic [CNT_W-1:0]         cnt, cntNext;
   logic                     holdStarted, holdStartedNext;
   logic                     detArmed, detArmedNext;
   logic [3:0]               pdTarget, pdTargetNext;
   logic [3:0]               rateTarget, rateTargetNext;
   logic [LANESNUMBER-1:0]   detLanes, detLanesNext;
   logic                     phyNext, okNext;
   logic [3*LANESNUMBER-1:0] rxNext;
   logic [3:0]               curPdNext, curRateNext;
   logic                     pdReq, rateReq, detReq;

   assign pdReq   = (PowerDown != CurrentPowerDown) && (PowerDown <= PD_P2);
   assign rateReq = (Rate != CurrentRate) && (Rate <= MAX_RATE_CODE) &&
                    ((CurrentPowerDown == PD_P0) || (CurrentPowerDown == PD_P1)) && (&TxElecIdle);
   assign detReq  = detArmed && (CurrentPowerDown == PD_P1) && (|(TxDetectRx_Loopback & TxElecIdle));

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state            <= RST_HOLD;
         cnt              <= '0;
         holdStarted      <= 1'b0;
         detArmed         <= 1'b1;
         pdTarget         <= PD_P1;
         rateTarget       <= RATE_GEN1;
         detLanes         <= '0;
         PhyStatus        <= 1'b1;
         PclkChangeOk     <= 1'b0;
         RxStatus         <= '0;
         CurrentPowerDown <= PD_P1;
         CurrentRate      <= RATE_GEN1;
      end else begin
         state            <= stateNext;
         cnt              <= cntNext;
         holdStarted      <= holdStartedNext;
         detArmed         <= detArmedNext;
         pdTarget         <= pdTargetNext;
         rateTarget       <= rateTargetNext;
         detLanes         <= detLanesNext;
         PhyStatus        <= phyNext;
         PclkChangeOk     <= okNext;
         RxStatus         <= rxNext;
         CurrentPowerDown <= curPdNext;
         CurrentRate      <= curRateNext;
      end
   end

   // Outputs are registered: the edge ending the last busy cycle raises PhyStatus for exactly one cycle.
   always_comb begin
      stateNext       = state;
      cntNext         = cnt;
      holdStartedNext = holdStarted;
      detArmedNext    = detArmed | ~(|TxDetectRx_Loopback);
      pdTargetNext    = pdTarget;
      rateTargetNext  = rateTarget;
      detLanesNext    = detLanes;
      phyNext         = 1'b0;
      okNext          = PclkChangeOk;
      rxNext          = '0;
      curPdNext       = CurrentPowerDown;
      curRateNext     = CurrentRate;

      case (state)
         RST_HOLD: begin
            phyNext = 1'b1;
            if (!holdStarted) begin
               holdStartedNext = 1'b1;
               cntNext         = RESET_LOAD;
            end else if (cnt == '0) begin
               phyNext   = 1'b0;
               stateNext = IDLE;
            end else begin
               cntNext = cnt - CNT_ONE;
            end
         end
         IDLE: begin
            if (pdReq) begin
               pdTargetNext = PowerDown;
               cntNext      = PD_LOAD;
               stateNext    = PD_BUSY;
            end else if (rateReq) begin
               rateTargetNext = Rate;
               okNext         = 1'b1;
               stateNext      = RATE_OK;
            end else if (detReq) begin
               detLanesNext = TxDetectRx_Loopback & TxElecIdle;
               cntNext      = DET_LOAD;
               stateNext    = DET_BUSY;
            end
         end
         PD_BUSY: begin
            if (cnt == '0) begin
               phyNext   = 1'b1;
               curPdNext = pdTarget;
               stateNext = IDLE;
            end else begin
               cntNext = cnt - CNT_ONE;
            end
         end
         DET_BUSY: begin
            if (cnt == '0) begin
               phyNext      = 1'b1;
               detArmedNext = 1'b0;
               stateNext    = IDLE;
               for (int i = 0; i < LANESNUMBER; i++) begin
                  rxNext[3*i +: 3] = (detLanes[i] && RxPresent[i]) ? RXSTAT_DETECTED : RXSTAT_NONE;
               end
            end else begin
               cntNext = cnt - CNT_ONE;
            end
         end
         RATE_OK: begin
            if (PclkChangeAck) begin
               cntNext   = RATE_LOAD;
               stateNext = RATE_SETTLE;
            end
         end
         RATE_SETTLE: begin
            if (cnt == '0) begin
               phyNext     = 1'b1;
               okNext      = 1'b0;
               curRateNext = rateTarget;
               stateNext   = RATE_DONE;
            end else begin
               cntNext = cnt - CNT_ONE;
            end
         end
         RATE_DONE: stateNext = WAIT_ACK_LOW;
         WAIT_ACK_LOW: begin
            if (!PclkChangeAck) stateNext = IDLE;
         end
         default: stateNext = RST_HOLD;
      endcase
   end

endmodule

// File: tb/tb_pipe_phy_ctrl.sv
// Self-checking bench for pipe_phy_ctrl: randomized scenarios against a latency/status model kept here.
module tb_pipe_phy_ctrl;

   localparam int LANES    = 16;
   localparam int RST_CYC  = 8;
   localparam int DET_LAT  = 8;
   localparam int PD_LAT   = 4;
   localparam int RATE_LAT = 16;
   localparam int MAXR     = 4;

   logic                 CLK = 1'b0;
   logic                 reset;
   logic [3:0]           PowerDown, Rate;
   logic [LANES-1:0]     TxDetectRx_Loopback, TxElecIdle, RxPresent;
   logic                 PclkChangeAck, PclkChangeOk, PhyStatus;
   logic [3*LANES-1:0]   RxStatus;
   logic [3:0]           CurrentPowerDown, CurrentRate;

   int         nAssert = 0;
   int         nFail   = 0;
   logic [3:0] mdlPd, mdlRate;

   always #5 CLK = ~CLK;

   pipe_phy_ctrl #(
      .LANESNUMBER(LANES), .RESET_CYCLES(RST_CYC), .DETECT_LATENCY(DET_LAT),
      .PD_LATENCY(PD_LAT), .RATE_LATENCY(RATE_LAT), .MAX_RATE(MAXR)
   ) dut (
      .CLK(CLK), .reset(reset), .PowerDown(PowerDown), .Rate(Rate),
      .TxDetectRx_Loopback(TxDetectRx_Loopback), .TxElecIdle(TxElecIdle),
      .RxPresent(RxPresent), .PclkChangeAck(PclkChangeAck), .PclkChangeOk(PclkChangeOk),
      .PhyStatus(PhyStatus), .RxStatus(RxStatus),
      .CurrentPowerDown(CurrentPowerDown), .CurrentRate(CurrentRate)
   );

   // RxStatus carries information only in a PhyStatus cycle.
   always @(negedge CLK) begin
      if (PhyStatus === 1'b0) begin
         nAssert++;
         if (RxStatus !== '0) begin
            nFail++;
            $display("FAIL rx_idle_zero: RxStatus=%h required 0", RxStatus);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic waitPhy(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (PhyStatus !== 1'b1 && n < limit);
      if (PhyStatus !== 1'b1) n = -1;
   endtask

   task automatic test_reset();
      int hi;
      reset = 1'b1; PowerDown = 4'd2; Rate = 4'd0; TxDetectRx_Loopback = '0;
      TxElecIdle = '1; RxPresent = '0; PclkChangeAck = 1'b0;
      repeat (3) tick();
      nAssert++;
      if ({PhyStatus, PclkChangeOk} !== 2'b10) begin
         nFail++; $display("FAIL reset_status: Phy/Ok=%b required 10", {PhyStatus, PclkChangeOk});
      end
      nAssert++;
      if (CurrentPowerDown !== 4'd2) begin
         nFail++; $display("FAIL reset_pd: got %0d required 2", CurrentPowerDown);
      end
      nAssert++;
      if (CurrentRate !== 4'd0) begin
         nFail++; $display("FAIL reset_rate: got %0d required 0", CurrentRate);
      end
      nAssert++;
      if (RxStatus !== '0) begin
         nFail++; $display("FAIL reset_rx: got %h required 0", RxStatus);
      end
      #1 reset = 1'b0;
      hi = 0;
      for (int i = 0; i < RST_CYC + 4; i++) begin
         tick();
         if (PhyStatus === 1'b1) hi++;
         else break;
      end
      nAssert++;
      if (hi != RST_CYC) begin
         nFail++; $display("FAIL reset_hold_len: PhyStatus high %0d cycles required %0d", hi, RST_CYC);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         nAssert++;
         if (PhyStatus !== 1'b0) begin
            nFail++; $display("FAIL reset_after_hold: PhyStatus=%b required 0", PhyStatus);
         end
      end
      nAssert++;
      if (CurrentPowerDown !== 4'd2) begin
         nFail++; $display("FAIL reset_pd_after: got %0d required 2", CurrentPowerDown);
      end
      mdlPd = 4'd2;
      mdlRate = 4'd0;
   endtask

   task automatic test_detect();
      logic [LANES-1:0] det, idle, pres, req;
      logic [2:0]       exp3, got3;
      int               n;
      for (int it = 0; it < 5; it++) begin
         if (it == 0) begin
            det = LANES'(3); idle = '1; pres = LANES'(1);
         end else begin
            det  = LANES'($urandom);
            idle = LANES'($urandom);
            pres = LANES'($urandom);
            if (det == '0) det = LANES'(1);
            if (it == 4) idle = ~det;
         end
         req = det & idle;
         TxElecIdle = idle; RxPresent = pres; TxDetectRx_Loopback = det;
         if (req != '0) begin
            waitPhy(DET_LAT + 4, n);
            nAssert++;
            if (n != DET_LAT + 1) begin
               nFail++; $display("FAIL det_latency it%0d: PhyStatus at cycle %0d required %0d", it, n, DET_LAT + 1);
            end
            for (int l = 0; l < LANES; l++) begin
               exp3 = (req[l] && pres[l]) ? 3'b011 : 3'b000;
               got3 = RxStatus[3*l +: 3];
               nAssert++;
               if (got3 !== exp3) begin
                  nFail++; $display("FAIL det_rxstatus it%0d lane%0d: got %b required %b", it, l, got3, exp3);
               end
            end
         end
         // Bits still held high: either no completion yet rearmed, or no qualifying lane at all.
         for (int k = 0; k < DET_LAT + 3; k++) begin
            tick();
            nAssert++;
            if (PhyStatus !== 1'b0) begin
               nFail++; $display("FAIL det_no_restart it%0d: PhyStatus=%b required 0", it, PhyStatus);
            end
         end
         TxDetectRx_Loopback = '0;
         tick();
      end
      TxElecIdle = '1;
   endtask

   task automatic test_power();
      logic [3:0] tgt;
      int         n;
      bit         legal;
      TxDetectRx_Loopback = '0; TxElecIdle = '1;
      for (int it = 0; it < 9; it++) begin
         if (it == 0) tgt = 4'd0;
         else if (it == 1) tgt = 4'd5;
         else if (it == 8) tgt = 4'd0;
         else tgt = 4'($urandom_range(0, 7));
         legal = (tgt <= 4'd3) && (tgt != mdlPd);
         PowerDown = tgt;
         if (legal) begin
            waitPhy(PD_LAT + 4, n);
            nAssert++;
            if (n != PD_LAT + 1) begin
               nFail++; $display("FAIL pd_latency it%0d: PhyStatus at cycle %0d required %0d", it, n, PD_LAT + 1);
            end
            nAssert++;
            if (CurrentPowerDown !== tgt) begin
               nFail++; $display("FAIL pd_current it%0d: got %0d required %0d", it, CurrentPowerDown, tgt);
            end
            mdlPd = tgt;
            tick();
            nAssert++;
            if (PhyStatus !== 1'b0) begin
               nFail++; $display("FAIL pd_pulse_width it%0d: PhyStatus=%b required 0", it, PhyStatus);
            end
         end else begin
            for (int k = 0; k < PD_LAT + 3; k++) begin
               tick();
               nAssert++;
               if (PhyStatus !== 1'b0 || CurrentPowerDown !== mdlPd) begin
                  nFail++; $display("FAIL pd_ignored it%0d code%0d: Phy=%b Pd=%0d required 0/%0d",
                                    it, tgt, PhyStatus, CurrentPowerDown, mdlPd);
               end
            end
         end
      end
   endtask

   task automatic test_rate();
      logic [3:0] tgt;
      int         n, ackDelay;
      bit         ackHigh;
      Rate = 4'(MAXR + 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         nAssert++;
         if (PclkChangeOk !== 1'b0) begin
            nFail++; $display("FAIL rate_illegal_code: Ok=%b required 0", PclkChangeOk);
         end
      end
      Rate = 4'd2; TxElecIdle = ~LANES'(1);
      for (int k = 0; k < 4; k++) begin
         tick();
         nAssert++;
         if (PclkChangeOk !== 1'b0) begin
            nFail++; $display("FAIL rate_not_idle: Ok=%b required 0", PclkChangeOk);
         end
      end
      TxElecIdle = '1;
      ackHigh = 1'b0;
      for (int it = 0; it < 4; it++) begin
         if (it == 0) tgt = 4'd2;
         else begin
            do tgt = 4'($urandom_range(0, MAXR)); while (tgt == mdlRate);
         end
         Rate = tgt;
         if (ackHigh) begin
            for (int k = 0; k < 3; k++) begin
               tick();
               nAssert++;
               if (PclkChangeOk !== 1'b0) begin
                  nFail++; $display("FAIL rate_wait_ack_low it%0d: Ok=%b required 0", it, PclkChangeOk);
               end
            end
            PclkChangeAck = 1'b0;
         end
         n = 0;
         do begin
            tick();
            n++;
         end while (PclkChangeOk !== 1'b1 && n < 8);
         nAssert++;
         if (n != (ackHigh ? 2 : 1) || PclkChangeOk !== 1'b1) begin
            nFail++; $display("FAIL rate_ok_latency it%0d: Ok=%b after %0d cycles required 1 after %0d",
                              it, PclkChangeOk, n, ackHigh ? 2 : 1);
         end
         nAssert++;
         if (CurrentRate !== mdlRate) begin
            nFail++; $display("FAIL rate_early it%0d: CurrentRate=%0d required %0d", it, CurrentRate, mdlRate);
         end
         ackDelay = (it == 0) ? 3 : int'($urandom_range(0, 5));
         for (int k = 0; k < ackDelay; k++) begin
            tick();
            nAssert++;
            if (PclkChangeOk !== 1'b1 || PhyStatus !== 1'b0) begin
               nFail++; $display("FAIL rate_hold_ok it%0d: Ok/Phy=%b%b required 10", it, PclkChangeOk, PhyStatus);
            end
         end
         PclkChangeAck = 1'b1;
         waitPhy(RATE_LAT + 4, n);
         nAssert++;
         if (n != RATE_LAT + 1) begin
            nFail++; $display("FAIL rate_settle it%0d: PhyStatus at cycle %0d required %0d", it, n, RATE_LAT + 1);
         end
         nAssert++;
         if (CurrentRate !== tgt || PclkChangeOk !== 1'b0) begin
            nFail++; $display("FAIL rate_done it%0d: Rate=%0d Ok=%b required %0d/0", it, CurrentRate, PclkChangeOk, tgt);
         end
         mdlRate = tgt;
         ackHigh = 1'b1;
      end
      tick();
      nAssert++;
      if (PhyStatus !== 1'b0) begin
         nFail++; $display("FAIL rate_pulse_width: PhyStatus=%b required 0", PhyStatus);
      end
      PclkChangeAck = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0] tgt;
      int         n, hi;
      PowerDown = 4'd2;
      waitPhy(PD_LAT + 4, n);
      nAssert++;
      if (n != PD_LAT + 1 || CurrentPowerDown !== 4'd2) begin
         nFail++; $display("FAIL b2b_to_p1: cycle %0d Pd=%0d required %0d/2", n, CurrentPowerDown, PD_LAT + 1);
      end
      mdlPd = 4'd2;
      tgt = (mdlRate == 4'd1) ? 4'd3 : 4'd1;
      PowerDown = 4'd0; Rate = tgt;
      waitPhy(PD_LAT + 4, n);
      nAssert++;
      if (n != PD_LAT + 1) begin
         nFail++; $display("FAIL b2b_pd_first: PhyStatus at cycle %0d required %0d", n, PD_LAT + 1);
      end
      nAssert++;
      if (CurrentPowerDown !== 4'd0 || PclkChangeOk !== 1'b0 || CurrentRate !== mdlRate) begin
         nFail++; $display("FAIL b2b_pd_state: Pd=%0d Ok=%b Rate=%0d required 0/0/%0d",
                           CurrentPowerDown, PclkChangeOk, CurrentRate, mdlRate);
      end
      tick();
      nAssert++;
      if (PclkChangeOk !== 1'b1 || PhyStatus !== 1'b0) begin
         nFail++; $display("FAIL b2b_rate_next: Ok/Phy=%b%b required 10", PclkChangeOk, PhyStatus);
      end
      PclkChangeAck = 1'b1;
      repeat (6) tick();
      nAssert++;
      if (PclkChangeOk !== 1'b1 || PhyStatus !== 1'b0) begin
         nFail++; $display("FAIL b2b_mid_settle: Ok/Phy=%b%b required 10", PclkChangeOk, PhyStatus);
      end
      reset = 1'b1; PowerDown = 4'd2; Rate = 4'd0; PclkChangeAck = 1'b0;
      #1;
      nAssert++;
      if (PclkChangeOk !== 1'b0 || PhyStatus !== 1'b1 || CurrentRate !== 4'd0 || CurrentPowerDown !== 4'd2) begin
         nFail++; $display("FAIL b2b_reset_abort: Ok=%b Phy=%b Rate=%0d Pd=%0d required 0/1/0/2",
                           PclkChangeOk, PhyStatus, CurrentRate, CurrentPowerDown);
      end
      repeat (2) tick();
      #1 reset = 1'b0;
      hi = 0;
      for (int i = 0; i < RST_CYC + 4; i++) begin
         tick();
         if (PhyStatus === 1'b1) hi++;
         else break;
      end
      nAssert++;
      if (hi != RST_CYC || CurrentRate !== 4'd0 || PclkChangeOk !== 1'b0) begin
         nFail++; $display("FAIL b2b_rehold: high %0d Rate=%0d Ok=%b required %0d/0/0",
                           hi, CurrentRate, PclkChangeOk, RST_CYC);
      end
      mdlPd = 4'd2;
      mdlRate = 4'd0;
   endtask

   initial begin
      test_reset();
      test_detect();
      test_power();
      test_rate();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
